// File: rtl/vx_raster_tile_walker_if.sv
// Tile-in / block-out handshake bundle for vx_raster_tile_walker.
// The walker takes the slave modport; the tile source / block sink takes master.
`ifndef RASTER_DIM_BITS
`define RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

interface vx_raster_tile_walker_if #(
    parameter int DIM_BITS  = `RASTER_DIM_BITS,
    parameter int DATA_BITS = `RASTER_DATA_BITS
);
    logic                                valid_in;
    logic                                ready_in;
    logic [DIM_BITS-1:0]                 xloc_in;
    logic [DIM_BITS-1:0]                 yloc_in;
    logic [2:0][2:0][DATA_BITS-1:0]      edges_in;
    logic [2:0][DATA_BITS-1:0]           extents_in;

    logic                                valid_out;
    logic                                ready_out;
    logic [DIM_BITS-1:0]                 xloc_out;
    logic [DIM_BITS-1:0]                 yloc_out;
    logic [2:0][2:0][DATA_BITS-1:0]      edges_out;

    modport master (
        output valid_in, xloc_in, yloc_in, edges_in, extents_in, ready_out,
        input  ready_in, valid_out, xloc_out, yloc_out, edges_out
    );

    modport slave (
        input  valid_in, xloc_in, yloc_in, edges_in, extents_in, ready_out,
        output ready_in, valid_out, xloc_out, yloc_out, edges_out
    );
endinterface

// File: rtl/vx_raster_tile_walker.sv
// Quad-tree depth-first tile walker: emits every overlapping 2^BLOCK_LOGSIZE block of a tile.
// Optional perf counters (perf_blocks/perf_stalls) enabled by defining PERF_RASTER_TILE_WALK_EN.
`ifndef RASTER_DIM_BITS
`define RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

module vx_raster_tile_walker #(
    parameter int TILE_LOGSIZE  = 5,
    parameter int BLOCK_LOGSIZE = 2,
    parameter int STACK_DEPTH   = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    vx_raster_tile_walker_if.slave   bus,
`ifdef PERF_RASTER_TILE_WALK_EN
    output logic [31:0]              perf_blocks,
    output logic [31:0]              perf_stalls,
`endif
    output logic                     tile_done
);
    localparam int DB   = `RASTER_DATA_BITS;
    localparam int DIMB = `RASTER_DIM_BITS;
    localparam int OW   = TILE_LOGSIZE;
    localparam int LW   = $clog2(TILE_LOGSIZE + 1);
    localparam int SPW  = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_TEST, S_POP} state_t;

    typedef struct packed {
        logic [OW-1:0]        x;
        logic [OW-1:0]        y;
        logic [LW-1:0]        k;
        logic [2:0][DB-1:0]   ev;
    } node_t;

    state_t                   state_q;
    node_t                    cur_q;
    node_t                    stack_q [STACK_DEPTH];
    logic [SPW-1:0]           sp_q;
    logic [1:0]               j_q;
    logic [2:0][DB-1:0]       a_q, b_q, ext_q;
    logic [DIMB-1:0]          org_x_q, org_y_q;
    logic                     ready_in_q, valid_out_q, tile_done_q;
    logic [DIMB-1:0]          xloc_out_q, yloc_out_q;
    logic [2:0][2:0][DB-1:0]  edges_out_q;

    node_t                    child;
    logic                     child_hit, child_leaf, push_now, step_done;
    logic [LW-1:0]            sh, ext_sh;
    logic [DB-1:0]            sum;

    // Child j of the current node, its edge values and overlap test
    always_comb begin
        sh        = cur_q.k - 1'b1;
        ext_sh    = LW'(TILE_LOGSIZE) - sh;
        child     = cur_q;
        child.k   = sh;
        child.x   = cur_q.x + (j_q[0] ? (OW'(1) << sh) : '0);
        child.y   = cur_q.y + (j_q[1] ? (OW'(1) << sh) : '0);
        child_hit = 1'b1;
        sum       = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            child.ev[i] = cur_q.ev[i] + (j_q[0] ? (a_q[i] << sh) : '0)
                                      + (j_q[1] ? (b_q[i] << sh) : '0);
            sum = child.ev[i] + (ext_q[i] >> ext_sh);
            if (sum[DB-1]) child_hit = 1'b0;
        end
        child_leaf = (cur_q.k == LW'(BLOCK_LOGSIZE + 1));
        push_now   = (state_q == S_TEST) && !valid_out_q && child_hit && !child_leaf;
        // a child is finished once skipped/pushed, or once its block handshakes
        step_done  = (state_q == S_TEST) &&
                     (valid_out_q ? bus.ready_out : !(child_hit && child_leaf));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sp_q        <= '0;
            j_q         <= '0;
            ready_in_q  <= 1'b0;
            valid_out_q <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_in_q <= 1'b1;
                    if (bus.valid_in && ready_in_q) begin
                        ready_in_q <= 1'b0;
                        org_x_q    <= bus.xloc_in;
                        org_y_q    <= bus.yloc_in;
                        for (int unsigned i = 0; i < 3; i++) begin
                            a_q[i]      <= bus.edges_in[i][2];
                            b_q[i]      <= bus.edges_in[i][1];
                            cur_q.ev[i] <= bus.edges_in[i][0];
                            ext_q[i]    <= bus.extents_in[i];
                        end
                        cur_q.x <= '0;
                        cur_q.y <= '0;
                        cur_q.k <= LW'(TILE_LOGSIZE);
                        j_q     <= '0;
                        state_q <= S_TEST;
                    end
                end
                S_TEST: begin
                    if (valid_out_q) begin
                        if (bus.ready_out) valid_out_q <= 1'b0;
                    end else if (child_hit && child_leaf) begin
                        valid_out_q <= 1'b1;
                        xloc_out_q  <= org_x_q + DIMB'(child.x);
                        yloc_out_q  <= org_y_q + DIMB'(child.y);
                        for (int unsigned i = 0; i < 3; i++)
                            edges_out_q[i] <= {a_q[i], b_q[i], child.ev[i]};
                    end
                    if (push_now) begin
                        assert (sp_q < SPW'(STACK_DEPTH));
                        stack_q[sp_q] <= child;
                        sp_q          <= sp_q + 1'b1;
                    end
                    if (step_done) begin
                        j_q <= j_q + 1'b1;
                        if (j_q == 2'd3) begin
                            if (sp_q != '0 || push_now) begin
                                state_q <= S_POP;
                            end else begin
                                tile_done_q <= 1'b1;
                                state_q     <= S_IDLE;
                            end
                        end
                    end
                end
                S_POP: begin
                    cur_q   <= stack_q[sp_q - 1'b1];
                    sp_q    <= sp_q - 1'b1;
                    j_q     <= '0;
                    state_q <= S_TEST;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_in  = ready_in_q;
    assign bus.valid_out = valid_out_q;
    assign bus.xloc_out  = xloc_out_q;
    assign bus.yloc_out  = yloc_out_q;
    assign bus.edges_out = edges_out_q;
    assign tile_done     = tile_done_q;

`ifdef PERF_RASTER_TILE_WALK_EN
    logic [31:0] perf_blocks_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_blocks_q <= '0;
            perf_stalls_q <= '0;
        end else if (valid_out_q) begin
            if (bus.ready_out) perf_blocks_q <= perf_blocks_q + 32'd1;
            else               perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_blocks = perf_blocks_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_vx_raster_tile_walker.sv
// Directed + randomized bench for vx_raster_tile_walker against a quad-tree reference model.
`ifndef RASTER_DIM_BITS
`define RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

module tb_vx_raster_tile_walker;
    localparam int T = 5;
    localparam int B = 2;
    localparam int N = T - B;
    localparam int D = `RASTER_DATA_BITS;
    localparam int W = `RASTER_DIM_BITS;

    typedef logic [2:0][2:0][D-1:0] edges_t;
    typedef logic [2:0][D-1:0]      ext_t;
    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        edges_t       e;
    } blk_t;
    localparam int BW = $bits(blk_t);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tile_done;
    always #5 clk = ~clk;

    vx_raster_tile_walker_if bus ();
`ifdef PERF_RASTER_TILE_WALK_EN
    logic [31:0] perf_blocks, perf_stalls;
`endif

    vx_raster_tile_walker #(
        .TILE_LOGSIZE (T),
        .BLOCK_LOGSIZE(B),
        .STACK_DEPTH  (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
`ifdef PERF_RASTER_TILE_WALK_EN
        .perf_blocks(perf_blocks),
        .perf_stalls(perf_stalls),
`endif
        .tile_done  (tile_done)
    );

    int   checks = 0;
    int   failures = 0;
    int   model_hs = 0;
    int   model_st = 0;
    blk_t exp_q[$];
    blk_t got_q[$];

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    // Reference: edge value of an absolute linear function at an offset
    function automatic logic [D-1:0] eval_at(input logic [2:0][D-1:0] ei, input int xo, input int yo);
        return ei[0] + ei[2] * D'(xo) + ei[1] * D'(yo);
    endfunction

    function automatic bit node_hit(input int xo, input int yo, input int lvl,
                                    input edges_t e, input ext_t ex);
        logic [D-1:0] s;
        for (int i = 0; i < 3; i++) begin
            s = eval_at(e[i], xo, yo) + (ex[i] >> (T - lvl));
            if (s[D-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Emission order as a base-4 key: inner levels visited j3..j0, leaf level j0..j3
    function automatic void build_expected(input logic [W-1:0] ox, input logic [W-1:0] oy,
                                           input edges_t e, input ext_t ex);
        exp_q.delete();
        for (int key = 0; key < (1 << (2 * N)); key++) begin
            int xo, yo, lvl, digit, j;
            bit ok;
            blk_t b;
            xo = 0; yo = 0; ok = 1'b1;
            for (int n = 0; n < N; n++) begin
                lvl   = T - 1 - n;
                digit = (key >> (2 * (N - 1 - n))) & 3;
                j     = (n == N - 1) ? digit : 3 - digit;
                xo   += (j % 2) << lvl;
                yo   += (j / 2) << lvl;
                if (!node_hit(xo, yo, lvl, e, ex)) ok = 1'b0;
            end
            if (ok) begin
                b.x = ox + W'(xo);
                b.y = oy + W'(yo);
                for (int i = 0; i < 3; i++) begin
                    b.e[i][2] = e[i][2];
                    b.e[i][1] = e[i][1];
                    b.e[i][0] = eval_at(e[i], xo, yo);
                end
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        @(negedge clk);
        chk("rst_valid_out", BW'(bus.valid_out), BW'(0));
        chk("rst_tile_done", BW'(tile_done), BW'(0));
        chk("rst_ready_in", BW'(bus.ready_in), BW'(0));
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        model_hs = 0;
        model_st = 0;
        @(negedge clk);
        chk("post_rst_ready_in", BW'(bus.ready_in), BW'(1));
    endtask

    task automatic run_tile(input string tag, input logic [W-1:0] ox, input logic [W-1:0] oy,
                            input edges_t e, input ext_t ex, input int duty, input int stop_after);
        int   dones;
        bit   finished, prev_stall, aborted;
        blk_t cur, held;
        build_expected(ox, oy, e, ex);
        got_q.delete();
        dones = 0; finished = 1'b0; prev_stall = 1'b0; aborted = 1'b0; held = '0;
        for (int i = 0; i < 20 && !bus.ready_in; i++) @(negedge clk);
        chk({tag, "_ready_in"}, BW'(bus.ready_in), BW'(1));
        bus.valid_in   = 1'b1;
        bus.xloc_in    = ox;
        bus.yloc_in    = oy;
        bus.edges_in   = e;
        bus.extents_in = ex;
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.xloc_in  = W'($urandom);
        bus.yloc_in  = W'($urandom);
        for (int i = 0; i < 3; i++) begin
            bus.extents_in[i] = D'($urandom);
            for (int k = 0; k < 3; k++) bus.edges_in[i][k] = D'($urandom);
        end
        for (int cyc = 0; cyc < 3000 && !finished && !aborted; cyc++) begin
            cur.x = bus.xloc_out;
            cur.y = bus.yloc_out;
            cur.e = bus.edges_out;
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, BW'(bus.valid_out), BW'(1));
                chk({tag, "_stall_data"}, cur, held);
            end
            if (tile_done) begin
                dones++;
                finished = 1'b1;
                chk({tag, "_done_ready_in"}, BW'(bus.ready_in), BW'(0));
                chk({tag, "_done_valid_out"}, BW'(bus.valid_out), BW'(0));
            end else begin
                bus.ready_out = ($urandom_range(99) < duty);
                prev_stall = 1'b0;
                if (bus.valid_out) begin
                    if (bus.ready_out) begin
                        got_q.push_back(cur);
                        model_hs++;
                    end else begin
                        model_st++;
                        prev_stall = 1'b1;
                        held = cur;
                    end
                end
                if (stop_after > 0 && got_q.size() == stop_after && bus.valid_out && bus.ready_out)
                    aborted = 1'b1;
                @(negedge clk);
            end
        end
        if (aborted) begin
            chk({tag, "_no_done_before_rst"}, BW'(tile_done), BW'(0));
            do_reset(3);
            for (int c = 0; c < 5; c++) begin
                chk({tag, "_quiet_valid"}, BW'(bus.valid_out), BW'(0));
                chk({tag, "_quiet_done"}, BW'(tile_done), BW'(0));
                @(negedge clk);
            end
        end else begin
            chk({tag, "_finished"}, BW'(finished), BW'(1));
            chk({tag, "_done_count"}, BW'(dones), BW'(1));
            @(negedge clk);
            chk({tag, "_done_pulse"}, BW'(tile_done), BW'(0));
            chk({tag, "_ready_after"}, BW'(bus.ready_in), BW'(1));
            chk({tag, "_block_count"}, BW'(got_q.size()), BW'(exp_q.size()));
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_blk%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        edges_t full_e, e;
        ext_t   zero_x, ex;
        logic [W-1:0] xo;

        bus.valid_in = 1'b0; bus.ready_out = 1'b0;
        bus.xloc_in = '0; bus.yloc_in = '0; bus.edges_in = '0; bus.extents_in = '0;
        full_e = '0;
        for (int i = 0; i < 3; i++) full_e[i][0] = D'(1);
        zero_x = '0;

        do_reset(3);

        run_tile("full", W'(64), W'(32), full_e, zero_x, 100, 0);
        chk("full_n64", BW'(got_q.size()), BW'(64));
        if (got_q.size() > 0) begin
            chk("full_first_x", BW'(got_q[0].x), BW'(88));
            chk("full_first_y", BW'(got_q[0].y), BW'(56));
        end

        e = full_e;
        e[0][0] = D'(-1000);
        run_tile("empty", W'(64), W'(32), e, zero_x, 100, 0);
        chk("empty_n0", BW'(got_q.size()), BW'(0));

        e = full_e;
        e[0][2] = D'(-1);
        e[0][0] = D'(15);
        run_tile("half", W'(64), W'(32), e, zero_x, 100, 0);
        chk("half_n32", BW'(got_q.size()), BW'(32));
        for (int i = 0; i < got_q.size(); i++) begin
            xo = got_q[i].x - W'(64);
            chk("half_xoff", BW'(xo < W'(16)), BW'(1));
            chk("half_eval", BW'(got_q[i].e[0][0]), BW'(D'(15) - D'(xo)));
        end

        do_reset(2);
        run_tile("bp", W'(64), W'(32), full_e, zero_x, 30, 0);
        chk("bp_n64", BW'(got_q.size()), BW'(64));
`ifdef PERF_RASTER_TILE_WALK_EN
        chk("perf_blocks", BW'(perf_blocks), BW'(64));
        chk("perf_stalls", BW'(perf_stalls), BW'(model_st));
`endif

        run_tile("midrst", W'(128), W'(64), full_e, zero_x, 70, 10);
        chk("midrst_n10", BW'(got_q.size()), BW'(10));
        e = full_e;
        e[0][2] = D'(-1);
        e[0][0] = D'(15);
        run_tile("after_rst", W'(32), W'(96), e, zero_x, 100, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 3; i++) begin
                e[i][2] = D'(int'($urandom_range(16)) - 8);
                e[i][1] = D'(int'($urandom_range(16)) - 8);
                e[i][0] = D'(int'($urandom_range(400)) - 200);
                ex[i]   = D'($urandom_range(400));
            end
            run_tile($sformatf("rand%0d", t), W'($urandom_range(200) * 32),
                     W'($urandom_range(200) * 32), e, ex, 40 + int'($urandom_range(60)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
